// File: rtl/pkt_pkg.sv
// pkt_pkg: pixel-format helpers shared by the stream packers
package pkt_pkg;
    localparam int MAX_KEEP = 256;

    function automatic int pix_bytes(input int pix_w);
        return (pix_w + 7) / 8;
    endfunction

    function automatic logic [MAX_KEEP-1:0] keep_mask(input int fill, input int pbytes, input int lane_w, input int ppb);
        logic [MAX_KEEP-1:0] m;
        m = '0;
        for (int j = 0; j < ppb; j++)
            for (int b = 0; b < pbytes; b++)
                if (j <= fill) m = m | (MAX_KEEP'(1) << (j * (lane_w / 8) + b));
        return m;
    endfunction
endpackage

// File: rtl/axis_skid_fifo2.sv
// axis_skid_fifo2: 2-entry registered-output stream buffer
module axis_skid_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] wr_data,
    input  logic         wr_en,
    output logic         wr_ready,
    output logic [W-1:0] rd_data,
    output logic         rd_valid,
    input  logic         rd_ready
);
    logic [1:0]   cnt, cnt_nxt;
    logic [W-1:0] spare;
    logic         rd;

    assign rd_valid = cnt != 2'd0;
    assign rd       = rd_valid & rd_ready;
    assign cnt_nxt  = cnt + {1'b0, wr_en} - {1'b0, rd};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            spare    <= '0;
            rd_data  <= '0;
            wr_ready <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            wr_ready <= cnt_nxt != 2'd2;
            if (rd)
                rd_data <= (cnt == 2'd2) ? spare : wr_data;
            else if (cnt == 2'd0 && wr_en)
                rd_data <= wr_data;
            if (wr_en && (cnt == 2'd2 || (cnt == 2'd1 && !rd)))
                spare <= wr_data;
        end
    end
endmodule

// File: rtl/packer_v3.sv
// packer_v3: packs pixels into AXI4-Stream beats with eol flush and sof tagging
module packer_v3
    import pkt_pkg::*;
#(
    parameter int PIX_W        = 24,
    parameter int LANE_W       = 32,
    parameter int PIX_PER_BEAT = 1
) (
    input  logic                                 aclk,
    input  logic                                 areset,
    input  logic [PIX_W-1:0]                     in_pix,
    input  logic                                 in_valid,
    input  logic                                 in_sof,
    input  logic                                 in_eol,
    output logic                                 in_ready,
    output logic [LANE_W*PIX_PER_BEAT-1:0]       out_stream_tdata,
    output logic [LANE_W*PIX_PER_BEAT/8-1:0]     out_stream_tkeep,
    output logic                                 out_stream_tlast,
    output logic                                 out_stream_tuser,
    output logic                                 out_stream_tvalid,
    input  logic                                 out_stream_tready,
    output logic                                 err_sof_midline
);
    localparam int OUT_W     = LANE_W * PIX_PER_BEAT;
    localparam int KEEP_W    = OUT_W / 8;
    localparam int PIX_BYTES = pix_bytes(PIX_W);
    localparam int FW        = PIX_PER_BEAT > 1 ? $clog2(PIX_PER_BEAT) : 1;
    localparam int W         = OUT_W + KEEP_W + 2;
    localparam logic [FW-1:0] LAST = FW'(PIX_PER_BEAT - 1);

    logic [OUT_W-1:0]  acc, base, beat;
    logic [KEEP_W-1:0] keep;
    logic [FW-1:0]     fill, eff;
    logic              sof_pending, accept, early_sof, complete;

    assign accept    = in_valid & in_ready;
    // an early sof restarts the beat so the sof pixel lands in lane 0
    assign early_sof = accept & in_sof & (fill != '0);
    assign eff       = early_sof ? '0 : fill;
    assign base      = early_sof ? '0 : acc;
    assign complete  = accept & (in_eol | (eff == LAST));
    assign keep      = KEEP_W'(keep_mask(int'(eff), PIX_BYTES, LANE_W, PIX_PER_BEAT));

    for (genvar g = 0; g < PIX_PER_BEAT; g++) begin : g_lane
        assign beat[g*LANE_W +: LANE_W] = (eff == FW'(g)) ? LANE_W'(in_pix) : base[g*LANE_W +: LANE_W];
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            acc             <= '0;
            fill            <= '0;
            sof_pending     <= 1'b0;
            err_sof_midline <= 1'b0;
        end else if (accept) begin
            acc             <= complete ? '0 : beat;
            fill            <= complete ? '0 : eff + 1'b1;
            sof_pending     <= ~complete & (sof_pending | in_sof);
            err_sof_midline <= err_sof_midline | early_sof;
        end
    end

    axis_skid_fifo2 #(.W(W)) u_fifo (
        .clk      (aclk),
        .rst      (areset),
        .wr_data  ({beat, keep, in_eol, sof_pending | in_sof}),
        .wr_en    (complete),
        .wr_ready (in_ready),
        .rd_data  ({out_stream_tdata, out_stream_tkeep, out_stream_tlast, out_stream_tuser}),
        .rd_valid (out_stream_tvalid),
        .rd_ready (out_stream_tready)
    );
endmodule

// File: tb/tb_packer_v3.sv
// tb_packer_v3: randomized scoreboard bench for packer_v3 plus a default-config line check
module tb_packer_v3;
    localparam int PW = 12, LW = 24, PPB = 4, OW = LW * PPB, KW = OW / 8;

    typedef struct {
        logic [OW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
        logic          u;
    } beat_t;

    logic clk = 1'b0, areset = 1'b1;
    always #5 clk = ~clk;

    logic [PW-1:0] in_pix = '0;
    logic          in_valid = 1'b0, in_sof = 1'b0, in_eol = 1'b0, in_ready;
    logic [OW-1:0] tdata;
    logic [KW-1:0] tkeep;
    logic          tlast, tuser, tvalid, tready = 1'b1, err;

    logic [23:0] d1_pix = '0;
    logic        d1_valid = 1'b0, d1_sof = 1'b0, d1_eol = 1'b0, d1_in_ready;
    logic [31:0] d1_tdata;
    logic [3:0]  d1_tkeep;
    logic        d1_tlast, d1_tuser, d1_tvalid, d1_err;
    logic        d1_tready = 1'b1;

    packer_v3 #(.PIX_W(PW), .LANE_W(LW), .PIX_PER_BEAT(PPB)) dut (
        .aclk(clk), .areset(areset), .in_pix(in_pix), .in_valid(in_valid), .in_sof(in_sof),
        .in_eol(in_eol), .in_ready(in_ready), .out_stream_tdata(tdata), .out_stream_tkeep(tkeep),
        .out_stream_tlast(tlast), .out_stream_tuser(tuser), .out_stream_tvalid(tvalid),
        .out_stream_tready(tready), .err_sof_midline(err)
    );

    packer_v3 d1 (
        .aclk(clk), .areset(areset), .in_pix(d1_pix), .in_valid(d1_valid), .in_sof(d1_sof),
        .in_eol(d1_eol), .in_ready(d1_in_ready), .out_stream_tdata(d1_tdata), .out_stream_tkeep(d1_tkeep),
        .out_stream_tlast(d1_tlast), .out_stream_tuser(d1_tuser), .out_stream_tvalid(d1_tvalid),
        .out_stream_tready(d1_tready), .err_sof_midline(d1_err)
    );

    int vectors = 0, miscompares = 0;
    beat_t exp_q[$];
    logic [PW-1:0] pend[$];
    logic m_sof = 1'b0, m_err = 1'b0;
    bit stalled = 0;
    logic [OW+KW+1:0] prev;

    task automatic model_push(input logic [PW-1:0] p, input logic s, input logic e);
        beat_t b;
        if (s && pend.size() != 0) begin
            pend.delete();
            m_err = 1'b1;
        end
        if (s) m_sof = 1'b1;
        pend.push_back(p);
        if (e || pend.size() == PPB) begin
            b.d = '0;
            b.k = '0;
            foreach (pend[i]) begin
                b.d[i*LW +: LW] = {12'h0, pend[i]};
                b.k[i*3 +: 3]   = 3'b011;
            end
            b.l = e;
            b.u = m_sof;
            exp_q.push_back(b);
            pend.delete();
            m_sof = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (areset) begin
            stalled = 0;
        end else begin
            if (stalled) begin
                vectors++;
                if (!tvalid || {tdata, tkeep, tlast, tuser} !== prev) begin
                    miscompares++;
                    $display("FAIL stall_stable got v=%b %h required v=1 %h", tvalid, {tdata, tkeep, tlast, tuser}, prev);
                end
            end
            stalled = tvalid && !tready;
            prev = {tdata, tkeep, tlast, tuser};
            if (tvalid && tready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_beat got %h with empty scoreboard", tdata);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    if ({tdata, tkeep, tlast, tuser} !== {e.d, e.k, e.l, e.u}) begin
                        miscompares++;
                        $display("FAIL beat got d=%h k=%h l=%b u=%b required d=%h k=%h l=%b u=%b",
                                 tdata, tkeep, tlast, tuser, e.d, e.k, e.l, e.u);
                    end
                end
            end
            if (in_valid && in_ready) model_push(in_pix, in_sof, in_eol);
        end
    end

    task automatic send(input logic [PW-1:0] p, input logic s, input logic e);
        bit t;
        int n = 0;
        in_pix = p; in_sof = s; in_eol = e; in_valid = 1'b1;
        do begin
            @(negedge clk);
            t = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!t && n < 200);
        if (!t) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout got in_ready=0 required 1 within 200 cycles");
        end
        in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        in_valid = 1'b0;
        tready = 1'b1;
        while ((exp_q.size() != 0 || tvalid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain got %0d beats outstanding required 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        vectors++;
        if ({tvalid, tdata, tkeep, tlast, tuser, err, d1_tvalid} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got v=%b d=%h k=%h l=%b u=%b e=%b required all zero", tvalid, tdata, tkeep, tlast, tuser, err);
        end
        @(posedge clk);
        #1 areset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({in_ready, d1_in_ready, tvalid} !== 3'b110) begin
            miscompares++;
            $display("FAIL reset_release got ready=%b d1_ready=%b tvalid=%b required 1 1 0", in_ready, d1_in_ready, tvalid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_default_line();
        logic [23:0] px[4] = '{24'h112233, 24'h223344, 24'h334455, 24'h445566};
        for (int i = 0; i <= 4; i++) begin
            @(posedge clk);
            #1;
            d1_valid = i < 4;
            d1_pix   = px[i % 4];
            d1_sof   = i == 0;
            d1_eol   = i == 3;
            if (i > 0) begin
                @(negedge clk);
                vectors++;
                if ({d1_tvalid, d1_in_ready, d1_tdata, d1_tkeep, d1_tuser, d1_tlast} !==
                    {1'b1, 1'b1, 8'h0, px[i-1], 4'b0111, (i == 1), (i == 4)}) begin
                    miscompares++;
                    $display("FAIL default_beat%0d got v=%b r=%b d=%h k=%b u=%b l=%b required v=1 r=1 d=%h k=0111 u=%b l=%b",
                             i - 1, d1_tvalid, d1_in_ready, d1_tdata, d1_tkeep, d1_tuser, d1_tlast, {8'h0, px[i-1]}, i == 1, i == 4);
                end
            end
        end
        @(negedge clk);
        vectors++;
        if (d1_tvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL default_idle got tvalid=%b required 0", d1_tvalid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_pack();
        tready = 1'b1;
        for (int i = 1; i <= 6; i++) send(PW'(i), i == 1, i == 6);
        drain();
    endtask

    task automatic test_backpressure();
        int got = 0;
        bit t;
        tready = 1'b0;
        in_valid = 1'b1; in_eol = 1'b1; in_sof = 1'b0; in_pix = PW'($urandom);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            t = in_valid && in_ready;
            if (t) got++;
            @(posedge clk);
            #1;
            if (t) in_pix = PW'($urandom);
        end
        @(negedge clk);
        vectors++;
        if (got != 2 || {in_ready, tvalid} !== 2'b01) begin
            miscompares++;
            $display("FAIL backpressure got accepted=%0d ready=%b tvalid=%b required 2 0 1", got, in_ready, tvalid);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_eol = 1'b0;
        drain();
    endtask

    task automatic test_early_sof();
        tready = 1'b1;
        send(12'h0a1, 1'b1, 1'b0);
        send(12'h0b2, 1'b0, 1'b0);
        send(12'h0c3, 1'b1, 1'b0);
        send(12'h0d4, 1'b0, 1'b0);
        send(12'h0e5, 1'b0, 1'b1);
        drain();
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL early_sof_err got %b required 1", err);
        end
    endtask

    task automatic test_random();
        int n = 0, cyc = 0;
        bit t;
        while (n < 1000 && cyc < 20000) begin
            @(negedge clk);
            t = in_valid && in_ready;
            if (t) n++;
            @(posedge clk);
            #1;
            cyc++;
            tready = ($urandom % 4) != 0;
            if (!in_valid || t) begin
                in_valid = ($urandom % 4) != 0;
                in_pix   = PW'($urandom);
                in_sof   = ($urandom % 16) == 0;
                in_eol   = ($urandom % 6) == 0;
            end
        end
        in_valid = 1'b0;
        vectors++;
        if (n < 1000) begin
            miscompares++;
            $display("FAIL random_timeout got %0d pixels required 1000", n);
        end
        drain();
        vectors++;
        if (err !== m_err) begin
            miscompares++;
            $display("FAIL random_err got %b required %b", err, m_err);
        end
    endtask

    task automatic test_reset_mid();
        tready = 1'b0;
        send(12'h111, 1'b0, 1'b1);
        send(12'h222, 1'b0, 1'b0);
        send(12'h333, 1'b0, 1'b0);
        areset = 1'b1;
        #1;
        vectors++;
        if ({tvalid, err} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_mid got tvalid=%b err=%b required 0 0", tvalid, err);
        end
        exp_q.delete();
        pend.delete();
        m_sof = 1'b0;
        m_err = 1'b0;
        @(posedge clk);
        #1 areset = 1'b0;
        tready = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        send(12'h444, 1'b1, 1'b0);
        send(12'h555, 1'b0, 1'b0);
        send(12'h666, 1'b0, 1'b1);
        drain();
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_err got %b required 0", err);
        end
    endtask

    initial begin
        test_reset();
        test_default_line();
        test_pack();
        test_backpressure();
        test_early_sof();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/packer_v3.md
Name: packer_v3

Overview:
- Parametrised pixel-to-AXI4-Stream packer feeding the video DMA / VDMA write path.
- Packs PIX_PER_BEAT pixels of PIX_W bits into one LANE_W*PIX_PER_BEAT-bit beat.
- Flushes partial beats at end-of-line with correct tkeep, and maps sof/eol onto tuser/tlast.
- A 2-entry output buffer breaks the combinational tready->ready path and sustains one beat per cycle.

Parameters:
- PIX_W, 24, pixel width in bits (1..LANE_W).
- LANE_W, 32, bits per pixel lane in the output word; multiple of 8, >= PIX_W.
- PIX_PER_BEAT, 1, pixels per output beat (1, 2, 4, 8).
- Derived localparams: OUT_W = LANE_W*PIX_PER_BEAT; KEEP_W = OUT_W/8; PIX_BYTES = ceil(PIX_W/8).

Ports:
- aclk  in  1  clock
- areset  in  1  asynchronous, active-high reset
- in_pix  in  PIX_W  pixel data
- in_valid  in  1  pixel valid
- in_sof  in  1  first pixel of frame
- in_eol  in  1  last pixel of line
- in_ready  out  1  packer can accept a pixel
- out_stream_tdata  out  OUT_W  packed beat; pixel k in lane k (bits k*LANE_W+:LANE_W); lane 0 holds the earliest pixel
- out_stream_tkeep  out  KEEP_W  byte enables
- out_stream_tlast  out  1  beat contains the eol pixel
- out_stream_tuser  out  1  beat contains the sof pixel
- out_stream_tvalid  out  1  beat valid
- out_stream_tready  in  1  downstream accept
- err_sof_midline  out  1  sticky: sof arrived while a partial beat was pending

Behaviour:
- Reset (async assert, sync release):
  - fill=0; FIFO empty; tvalid=0, tlast=0, tuser=0, tdata=0, tkeep=0; err_sof_midline=0.
  - in_ready=1 one cycle after release.
- Handshakes:
  - Input transfer when in_valid & in_ready; output transfer when tvalid & tready.
  - in_valid is ignored when in_ready=0.
- Accumulator: lane register array, fill counter 0..PIX_PER_BEAT-1, sof_pending flag.
  - On each accepted pixel: zero-extend to LANE_W and write into lane[fill].
  - If in_sof is accepted, sof_pending is set.
- Beat completion: occurs on the accepted pixel where fill==PIX_PER_BEAT-1 or in_eol=1.
  - Push {lanes, keep, tlast=in_eol, tuser=sof_pending|in_sof} into the FIFO.
  - fill<-0; sof_pending<-0.
  - keep: for each lane j<=fill, the low PIX_BYTES bytes = 1; all other bytes = 0. Unused lanes in tdata = 0.
  - Example: PIX_W=24, LANE_W=32, PIX_PER_BEAT=1 gives keep=4'b0111 on every beat.
- Early sof: in_sof accepted while fill!=0.
  - Discard the partial beat; set err_sof_midline (sticky until reset).
  - The sof pixel becomes lane 0 of a new beat.
- Output FIFO: 2 entries, registered outputs.
  - Latency: the completing pixel accepted in cycle N gives tvalid=1 in cycle N+1.
  - Simultaneous push and pop is allowed at any occupancy, including count 2 with a pop.
  - tdata/tkeep/tlast/tuser stay stable while tvalid & !tready.
- in_ready: registered; equals (next FIFO count < 2), computed from registered count plus this cycle's push and pop.
  - No combinational path from out_stream_tready to in_ready.
  - Full throughput (1 pixel/cycle, PIX_PER_BEAT=1) is sustained while tready=1.
- Non-completing pixels (fill<PIX_PER_BEAT-1, no eol) are accepted whenever in_ready=1.
- Reset mid-frame: all partial and buffered data is dropped; no beat is emitted after reset release until new pixels arrive.

Decomposition:
- Shared package pkt_pkg: pixel-format constants (PIX_BYTES computation function); KEEP mask-generation function keep_mask(fill, PIX_BYTES, LANE_W, PIX_PER_BEAT).
- One sub-module: axis_skid_fifo2 (2-entry registered-output buffer, parametrised width). It is reused by later stream blocks.

Test Plan:
- Defaults, line of 4 pixels 0x112233..0x445566 (eol on 4th), sof on 1st, tready=1 -> 4 beats, tdata={8'h0,pix}, tkeep=0111, tuser on beat0 only, tlast on beat3, one beat per cycle, first tvalid 1 cycle after first accept.
- PIX_W=8, LANE_W=8, PIX_PER_BEAT=4, pixels 01..06 with eol on 06 -> beat0 tdata=0x04030201 keep=1111; beat1 tdata=0x00000605 keep=0011 tlast=1.
- Backpressure: tready=0 with continuous in_valid -> exactly 2 beats buffered, in_ready=0 the cycle after the 2nd push; release tready -> beats out in order, none lost or duplicated.
- Random tready/in_valid over 1000 pixels vs scoreboard model -> byte-exact match, tdata stable while stalled.
- PIX_PER_BEAT=4, sof after 2 pixels without eol -> no partial beat emitted, err_sof_midline=1, next beat has tuser=1 with lane0 = sof pixel.
- areset asserted with 1 beat in FIFO and fill=2 -> tvalid=0 immediately; after release, next line packs from lane 0 with err_sof_midline=0.
